// File: rtl/vec_mac_pkg.sv
// rtl/vec_mac_pkg.sv - uop field layout and FSM state encoding for vec_mac_pe
package vec_mac_pkg;

    localparam int UOP_N_LSB = 0;
    localparam int UOP_N_W   = 8;
    localparam int UOP_UNS   = 8;
    localparam int UOP_RELU  = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/vec_mac_tree.sv
// rtl/vec_mac_tree.sv - LANES multipliers feeding a registered adder tree, 2-cycle latency
module vec_mac_tree #(
    parameter int LANES = 32,
    parameter int DW    = 16,
    parameter int SUM_W = 2*DW + $clog2(LANES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_en,
    input  logic                i_uns,
    input  logic [LANES*DW-1:0] i_a,
    input  logic [LANES*DW-1:0] i_b,
    output logic [SUM_W-1:0]    o_sum,
    output logic                o_valid
);

    logic [2*DW-1:0] r_prod [LANES];
    logic            r_prod_valid;
    logic [SUM_W-1:0] r_sum;
    logic            r_sum_valid;
    logic [SUM_W-1:0] w_tree;

    // One extra bit per operand lets a single signed multiplier serve both modes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) r_prod[i] <= '0;
            r_prod_valid <= 1'b0;
            r_sum        <= '0;
            r_sum_valid  <= 1'b0;
        end else begin
            r_prod_valid <= i_en;
            r_sum_valid  <= r_prod_valid;
            if (i_en) begin
                for (int i = 0; i < LANES; i++) begin
                    r_prod[i] <= (2*DW)'(
                        $signed({~i_uns & i_a[i*DW+DW-1], i_a[i*DW +: DW]}) *
                        $signed({~i_uns & i_b[i*DW+DW-1], i_b[i*DW +: DW]}));
                end
            end
            if (r_prod_valid) r_sum <= w_tree;
        end
    end

    always_comb begin
        w_tree = '0;
        for (int i = 0; i < LANES; i++) begin
            w_tree = w_tree + SUM_W'($signed({~i_uns & r_prod[i][2*DW-1], r_prod[i]}));
        end
    end

    assign o_sum   = r_sum;
    assign o_valid = r_sum_valid;

endmodule

// File: rtl/vec_mac_pe.sv
// rtl/vec_mac_pe.sv - dot-product PE: uop FSM, beat/drain counters, accumulator, ReLU, result port
module vec_mac_pe
    import vec_mac_pkg::*;
#(
    parameter int LANES = 32,
    parameter int DW    = 16,
    parameter int ACC_W = 32,
    parameter int UOP_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [UOP_W-1:0]    uop,
    input  logic                uop_valid,
    output logic                uop_ready,
    input  logic [LANES*DW-1:0] neuron,
    input  logic                neuron_valid,
    output logic                neuron_ready,
    input  logic [LANES*DW-1:0] weight,
    input  logic                weight_valid,
    output logic                weight_ready,
    output logic [ACC_W-1:0]    result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                busy
);

    localparam int SUM_W = 2*DW + $clog2(LANES);
    localparam logic [UOP_N_W-1:0] N_ONE = 1;

    state_t             r_state;
    logic [UOP_N_W-1:0] r_n;
    logic [UOP_N_W-1:0] r_beats;
    logic [1:0]         r_drain;
    logic               r_uns;
    logic               r_relu;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_result;
    logic               r_result_valid;
    logic               r_uop_ready;

    logic               w_fire;
    logic [SUM_W-1:0]   w_sum;
    logic               w_sum_valid;
    logic [ACC_W-1:0]   w_sum_acc;

    assign w_fire = (r_state == ST_ACC) & neuron_valid & weight_valid;

    vec_mac_tree #(.LANES(LANES), .DW(DW), .SUM_W(SUM_W)) u_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_fire),
        .i_uns   (r_uns),
        .i_a     (neuron),
        .i_b     (weight),
        .o_sum   (w_sum),
        .o_valid (w_sum_valid)
    );

    // Sign- or zero-extend the tree sum to the accumulator; truncation when narrower is the intended wrap.
    assign w_sum_acc = ACC_W'($signed({~r_uns & w_sum[SUM_W-1], w_sum}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_n            <= '0;
            r_beats        <= '0;
            r_drain        <= '0;
            r_uns          <= 1'b0;
            r_relu         <= 1'b0;
            r_acc          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_uop_ready    <= 1'b0;
        end else begin
            if (w_sum_valid) r_acc <= r_acc + w_sum_acc;
            case (r_state)
                ST_IDLE: begin
                    r_uop_ready <= 1'b1;
                    if (uop_valid && r_uop_ready) begin
                        r_n         <= uop[UOP_N_LSB +: UOP_N_W];
                        r_uns       <= uop[UOP_UNS];
                        r_relu      <= uop[UOP_RELU];
                        r_acc       <= '0;
                        r_beats     <= '0;
                        r_uop_ready <= 1'b0;
                        if (uop[UOP_N_LSB +: UOP_N_W] == '0) begin
                            r_result       <= '0;
                            r_result_valid <= 1'b1;
                            r_state        <= ST_OUT;
                        end else begin
                            r_state <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (w_fire) begin
                        r_beats <= r_beats + N_ONE;
                        if (r_beats == r_n - N_ONE) begin
                            r_drain <= '0;
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Two edges for the product and sum stages, the third sees the final acc.
                    r_drain <= r_drain + 2'd1;
                    if (r_drain == 2'd2) begin
                        r_result       <= (r_relu && r_acc[ACC_W-1]) ? '0 : r_acc;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_uop_ready    <= 1'b1;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign uop_ready    = r_uop_ready;
    assign neuron_ready = w_fire;
    assign weight_ready = w_fire;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vec_mac_pe.sv
// tb/tb_vec_mac_pe.sv - randomized self-checking bench for vec_mac_pe against a dot-product model
module tb_vec_mac_pe;

    localparam int LANES = 32;
    localparam int DW    = 16;
    localparam int ACC_W = 32;
    localparam int UOP_W = 10;
    localparam int BW    = LANES*DW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [UOP_W-1:0] uop;
    logic             uop_valid;
    logic             uop_ready;
    logic [BW-1:0]    neuron;
    logic             neuron_valid;
    logic             neuron_ready;
    logic [BW-1:0]    weight;
    logic             weight_valid;
    logic             weight_ready;
    logic [ACC_W-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             busy;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int fire_cnt = 0;
    int desync = 0;

    logic [BW-1:0] nb[$];
    logic [BW-1:0] wb[$];

    vec_mac_pe #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .UOP_W(UOP_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uop          (uop),
        .uop_valid    (uop_valid),
        .uop_ready    (uop_ready),
        .neuron       (neuron),
        .neuron_valid (neuron_valid),
        .neuron_ready (neuron_ready),
        .weight       (weight),
        .weight_valid (weight_valid),
        .weight_ready (weight_ready),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (neuron_valid && neuron_ready && weight_valid && weight_ready) fire_cnt++;
            if (neuron_ready !== weight_ready) desync++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [UOP_W-1:0] mk_uop(input int n, input bit uns, input bit relu);
        logic [7:0] nn;
        nn = 8'(n);
        return {relu, uns, nn};
    endfunction

    // Reference: plain integer dot product over all queued beats, then wrap and ReLU.
    function automatic logic [ACC_W-1:0] model(input int n, input bit uns, input bit relu);
        longint acc;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        longint av;
        longint bv;
        logic [ACC_W-1:0] r;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            for (int l = 0; l < LANES; l++) begin
                a = nb[k][l*DW +: DW];
                b = wb[k][l*DW +: DW];
                if (uns) begin
                    av = longint'({48'd0, a});
                    bv = longint'({48'd0, b});
                end else begin
                    av = longint'($signed(a));
                    bv = longint'($signed(b));
                end
                acc = acc + av * bv;
            end
        end
        r = acc[ACC_W-1:0];
        if (relu && r[ACC_W-1]) r = '0;
        return r;
    endfunction

    task automatic fill_const(input int n, input logic [DW-1:0] ne, input logic [DW-1:0] we);
        nb.delete();
        wb.delete();
        for (int k = 0; k < n; k++) begin
            nb.push_back({LANES{ne}});
            wb.push_back({LANES{we}});
        end
    endtask

    task automatic fill_rand(input int n);
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        nb.delete();
        wb.delete();
        for (int k = 0; k < n; k++) begin
            for (int l = 0; l < LANES; l++) begin
                a[l*DW +: DW] = DW'($urandom);
                b[l*DW +: DW] = DW'($urandom);
            end
            nb.push_back(a);
            wb.push_back(b);
        end
    endtask

    task automatic send_uop(input logic [UOP_W-1:0] u, input int pct);
        bit taken;
        taken = 1'b0;
        for (int g = 0; g < 300 && !taken; g++) begin
            uop = u;
            uop_valid = ($urandom_range(0, 99) < pct);
            #1;
            taken = uop_valid && uop_ready;
            @(posedge clk); #1;
        end
        uop_valid = 1'b0;
        vecs++;
        if (!taken) begin
            errs++;
            $display("FAIL uop_accept: accepted=%0d required=1", taken);
        end
    endtask

    task automatic drive_beats(input int n, input int pct, input bit hold, output int last_cyc);
        int b;
        bit f;
        b = 0;
        last_cyc = -1;
        for (int g = 0; g < 3000 && b < n; g++) begin
            neuron = nb[b];
            weight = wb[b];
            neuron_valid = ($urandom_range(0, 99) < pct);
            weight_valid = ($urandom_range(0, 99) < pct);
            #1;
            f = neuron_valid && neuron_ready;
            @(posedge clk); #1;
            if (f) begin
                b++;
                last_cyc = cyc;
            end
        end
        neuron = BW'({LANES{$urandom}});
        weight = BW'({LANES{$urandom}});
        neuron_valid = hold;
        weight_valid = hold;
        vecs++;
        if (b != n) begin
            errs++;
            $display("FAIL beat_drive: beats fired=%0d required=%0d", b, n);
        end
    endtask

    task automatic wait_result(input int pct, output logic [ACC_W-1:0] r, output int rv_cyc);
        bit hs;
        hs = 1'b0;
        rv_cyc = -1;
        r = 'x;
        for (int g = 0; g < 500 && !hs; g++) begin
            if (result_valid && rv_cyc < 0) rv_cyc = cyc;
            result_ready = ($urandom_range(0, 99) < pct);
            #1;
            if (result_valid && result_ready) begin
                r = result;
                hs = 1'b1;
            end
            @(posedge clk); #1;
        end
        result_ready = 1'b0;
        vecs++;
        if (!hs) begin
            errs++;
            $display("FAIL result_handshake: completed=%0d required=1", hs);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        uop = '0; uop_valid = 1'b0;
        neuron = '0; neuron_valid = 1'b0;
        weight = '0; weight_valid = 1'b0;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vecs++; if (uop_ready !== 1'b0) begin errs++; $display("FAIL reset_uop_ready: got %b want 0", uop_ready); end
        vecs++; if (neuron_ready !== 1'b0) begin errs++; $display("FAIL reset_neuron_ready: got %b want 0", neuron_ready); end
        vecs++; if (weight_ready !== 1'b0) begin errs++; $display("FAIL reset_weight_ready: got %b want 0", weight_ready); end
        vecs++; if (result_valid !== 1'b0) begin errs++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
        vecs++; if (result !== '0) begin errs++; $display("FAIL reset_result: got %h want 0", result); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vecs++; if (uop_ready !== 1'b1) begin errs++; $display("FAIL idle_uop_ready: got %b want 1", uop_ready); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_signed_basic();
        logic [ACC_W-1:0] r;
        int lc;
        int rc;
        int f0;
        fill_const(4, 16'd1, 16'd2);
        f0 = fire_cnt;
        send_uop(mk_uop(4, 0, 0), 100);
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy: got %b want 1", busy); end
        drive_beats(4, 100, 1'b1, lc);
        wait_result(100, r, rc);
        neuron_valid = 1'b0; weight_valid = 1'b0;
        vecs++; if (r !== 32'd256 || r !== model(4, 0, 0)) begin errs++; $display("FAIL basic_result: got %h want %h", r, 32'd256); end
        vecs++; if (rc - lc !== 3) begin errs++; $display("FAIL basic_latency: got %0d want 3", rc - lc); end
        vecs++; if (fire_cnt - f0 !== 4) begin errs++; $display("FAIL basic_beats: got %0d want 4", fire_cnt - f0); end
        vecs++; if (result_valid !== 1'b0) begin errs++; $display("FAIL basic_pulse: got %b want 0", result_valid); end
    endtask

    task automatic test_negative_relu();
        logic [ACC_W-1:0] r;
        int lc;
        int rc;
        for (int rl = 0; rl < 2; rl++) begin
            fill_const(2, 16'hFFFD, 16'd5);
            send_uop(mk_uop(2, 0, rl[0]), 100);
            drive_beats(2, 100, 1'b0, lc);
            wait_result(100, r, rc);
            vecs++;
            if (r !== (rl == 0 ? 32'hFFFFFC40 : 32'h0) || r !== model(2, 0, rl[0])) begin
                errs++;
                $display("FAIL neg_relu%0d: got %h want %h", rl, r, (rl == 0 ? 32'hFFFFFC40 : 32'h0));
            end
        end
    endtask

    task automatic test_unsigned_wrap();
        logic [ACC_W-1:0] r;
        int lc;
        int rc;
        fill_const(1, 16'hFFFF, 16'hFFFF);
        send_uop(mk_uop(1, 1, 0), 100);
        drive_beats(1, 100, 1'b0, lc);
        wait_result(100, r, rc);
        vecs++; if (r !== 32'hFFC00020) begin errs++; $display("FAIL unsigned_wrap: got %h want ffc00020", r); end
        fill_const(1, 16'hFFFF, 16'hFFFF);
        send_uop(mk_uop(1, 0, 0), 100);
        drive_beats(1, 100, 1'b0, lc);
        wait_result(100, r, rc);
        vecs++; if (r !== 32'd32) begin errs++; $display("FAIL signed_minus1: got %h want 20", r); end
    endtask

    task automatic test_random_valids();
        logic [ACC_W-1:0] r;
        logic [ACC_W-1:0] e;
        int lc;
        int rc;
        int f0;
        int d0;
        bit uns;
        bit rl;
        f0 = fire_cnt;
        d0 = desync;
        for (int k = 0; k < 4; k++) begin
            fill_rand(35);
            uns = 1'($urandom);
            rl = 1'($urandom);
            e = model(35, uns, rl);
            send_uop(mk_uop(35, uns, rl), 50);
            drive_beats(35, 60, 1'b0, lc);
            wait_result(50, r, rc);
            vecs++; if (r !== e) begin errs++; $display("FAIL random_uop%0d: got %h want %h (uns=%0d relu=%0d)", k, r, e, uns, rl); end
        end
        vecs++; if (fire_cnt - f0 !== 140) begin errs++; $display("FAIL random_beats: got %0d want 140", fire_cnt - f0); end
        vecs++; if (desync - d0 !== 0) begin errs++; $display("FAIL random_desync: got %0d want 0", desync - d0); end
    endtask

    task automatic test_backpressure_n0();
        logic [ACC_W-1:0] e;
        int lc;
        int bad;
        bit seen;
        fill_rand(1);
        e = model(1, 0, 0);
        send_uop(mk_uop(1, 0, 0), 100);
        drive_beats(1, 100, 1'b0, lc);
        seen = 1'b0;
        for (int g = 0; g < 20 && !seen; g++) begin
            if (result_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        vecs++; if (!seen) begin errs++; $display("FAIL bp_valid: got 0 want 1"); end
        uop = mk_uop(0, 0, 0);
        uop_valid = 1'b1;
        bad = 0;
        for (int g = 0; g < 10; g++) begin
            if (result !== e || result_valid !== 1'b1 || uop_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        vecs++; if (bad !== 0) begin errs++; $display("FAIL bp_hold: bad cycles %0d want 0", bad); end
        vecs++; if (result !== e) begin errs++; $display("FAIL bp_result: got %h want %h", result, e); end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        vecs++; if (result_valid !== 1'b0 || uop_ready !== 1'b1) begin errs++; $display("FAIL bp_release: valid=%b ready=%b want valid=0 ready=1", result_valid, uop_ready); end
        @(posedge clk); #1;
        uop_valid = 1'b0;
        vecs++; if (result_valid !== 1'b1 || result !== '0 || uop_ready !== 1'b0) begin errs++; $display("FAIL n0_result: valid=%b result=%h ready=%b want 1/0/0", result_valid, result, uop_ready); end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        vecs++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errs++; $display("FAIL n0_done: busy=%b valid=%b want 0/0", busy, result_valid); end
    endtask

    task automatic test_reset_mid();
        logic [ACC_W-1:0] r;
        logic [ACC_W-1:0] e;
        int lc;
        int rc;
        int bad;
        fill_const(4, 16'd7, 16'd9);
        send_uop(mk_uop(4, 0, 0), 100);
        drive_beats(2, 100, 1'b1, lc);
        rst_n = 1'b0;
        #1;
        bad = 0;
        for (int g = 0; g < 3; g++) begin
            if (uop_ready !== 1'b0 || neuron_ready !== 1'b0 || weight_ready !== 1'b0 ||
                result_valid !== 1'b0 || result !== '0 || busy !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        vecs++; if (bad !== 0) begin errs++; $display("FAIL midreset_outputs: bad samples %0d want 0", bad); end
        neuron_valid = 1'b0; weight_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_rand(2);
        e = model(2, 1, 0);
        send_uop(mk_uop(2, 1, 0), 100);
        drive_beats(2, 100, 1'b0, lc);
        wait_result(100, r, rc);
        vecs++; if (r !== e) begin errs++; $display("FAIL midreset_rerun: got %h want %h", r, e); end
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_negative_relu();
        test_unsigned_wrap();
        test_random_valids();
        test_backpressure_n0();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
